// File: rtl/bootstrap_loader.sv
// Bootstrap loader: streams bytes from an external source into the
// microcode SRAM, then releases the CPU reset.
module bootstrap_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int LAST_ADDR  = 4095
) (
   input  logic                  CLK,
   input  logic                  N_RST,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
   output logic [DATA_WIDTH-1:0] BOOTSTRAP_DATA,
   output logic                  BOOTSTRAP_N_WE,
   output logic                  N_BOOTED,
   output logic                  CPU_N_RST
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_n_we;
   logic                  r_n_booted;
   logic                  r_cpu_n_rst;
   logic                  w_accept;
   logic                  w_last;

   assign w_accept = (r_state == S_WAIT) && IN_VALID;
   assign w_last   = (r_addr == LAST);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = S_WAIT;
         S_WAIT:  w_next = IN_VALID ? S_SETUP : S_WAIT;
         S_SETUP: w_next = S_WRITE;
         S_WRITE: w_next = S_HOLD;
         S_HOLD:  w_next = w_last ? S_DONE : S_WAIT;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobe and boot flags are registered from the next state so they
   // change cleanly on the same edge as the state they belong to.
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_n_we      <= 1'b1;
         r_n_booted  <= 1'b1;
         r_cpu_n_rst <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_n_we      <= (w_next != S_WRITE);
         r_n_booted  <= (w_next != S_DONE);
         r_cpu_n_rst <= (w_next == S_DONE);
         if (w_accept) begin
            r_data <= IN_DATA;
         end
         if ((r_state == S_HOLD) && !w_last) begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   assign IN_READY       = (r_state == S_WAIT);
   assign BOOTSTRAP_ADDR = r_addr;
   assign BOOTSTRAP_DATA = r_data;
   assign BOOTSTRAP_N_WE = r_n_we;
   assign N_BOOTED       = r_n_booted;
   assign CPU_N_RST      = r_cpu_n_rst;

endmodule

// File: tb/tb_bootstrap_loader.sv
// Bench for bootstrap_loader: a full-image instance and a 4-byte
// instance checked against a handshake-queue scoreboard.
module tb_bootstrap_loader;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst0, v0, rdy0, nwe0, nb0, cr0;
   logic [7:0]  d0, bd0;
   logic [11:0] a0;
   logic        rst1, v1, rdy1, nwe1, nb1, cr1;
   logic [7:0]  d1, bd1;
   logic [11:0] a1;

   bootstrap_loader u0 (
      .CLK(CLK), .N_RST(rst0), .IN_DATA(d0), .IN_VALID(v0),
      .IN_READY(rdy0), .BOOTSTRAP_ADDR(a0), .BOOTSTRAP_DATA(bd0),
      .BOOTSTRAP_N_WE(nwe0), .N_BOOTED(nb0), .CPU_N_RST(cr0)
   );

   bootstrap_loader #(.LAST_ADDR(3)) u1 (
      .CLK(CLK), .N_RST(rst1), .IN_DATA(d1), .IN_VALID(v1),
      .IN_READY(rdy1), .BOOTSTRAP_ADDR(a1), .BOOTSTRAP_DATA(bd1),
      .BOOTSTRAP_N_WE(nwe1), .N_BOOTED(nb1), .CPU_N_RST(cr1)
   );

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   int          ea[2];
   int          wr[2];
   logic        pwe[2];
   logic [11:0] pa[2];
   logic [7:0]  pd[2];
   logic [7:0]  pat[4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every accepted byte must appear exactly once, in order, at the
   // next sequential address, framed by a stable setup and hold cycle.
   task automatic mon(input int j, input logic rst, input logic nwe,
                      input logic nb, input logic cr,
                      input logic [11:0] a, input logic [7:0] d,
                      input logic hs, input logic [7:0] hd);
      logic [7:0] e;
      if (!rst) begin
         ea[j] = 0;
         wr[j] = 0;
         pwe[j] = 1'b1;
         if (j == 0) q0.delete(); else q1.delete();
         return;
      end
      if (hs) begin
         if (j == 0) q0.push_back(hd); else q1.push_back(hd);
      end
      chk("nboot_vs_cpurst", nb, !cr);
      if (!nwe) begin
         chk("we_unbooted", nb, 1);
         chk("we_one_cycle", pwe[j], 1);
         chk("setup_addr", a, pa[j]);
         chk("setup_data", d, pd[j]);
         if ((j == 0 ? q0.size() : q1.size()) == 0) begin
            chk("spurious_we", nwe, 1);
         end else begin
            e = (j == 0) ? q0.pop_front() : q1.pop_front();
            chk("wr_addr", a, ea[j]);
            chk("wr_data", d, e);
            ea[j]++;
            wr[j]++;
         end
      end
      if (!pwe[j]) begin
         chk("hold_addr", a, pa[j]);
         chk("hold_data", d, pd[j]);
      end
      pwe[j] = nwe;
      pa[j]  = a;
      pd[j]  = d;
   endtask

   task automatic tick();
      logic       hs0, hs1;
      logic [7:0] hd0, hd1;
      hs0 = v0 && rdy0;
      hs1 = v1 && rdy1;
      hd0 = d0;
      hd1 = d1;
      @(negedge CLK);
      mon(0, rst0, nwe0, nb0, cr0, a0, bd0, hs0, hd0);
      mon(1, rst1, nwe1, nb1, cr1, a1, bd1, hs1, hd1);
      #1;
   endtask

   initial begin
      int   idx, cnt, fall;
      logic acc, need, found;
      rst0 = 0; rst1 = 0;
      v0 = 0; v1 = 0; d0 = 0; d1 = 0;
      tick();
      tick();
      chk("rst_ready0", rdy0, 0);
      chk("rst_addr0", a0, 0);
      chk("rst_data0", bd0, 0);
      chk("rst_nwe0", nwe0, 1);
      chk("rst_nboot0", nb0, 1);
      chk("rst_cpurst0", cr0, 0);
      chk("rst_ready1", rdy1, 0);
      chk("rst_addr1", a1, 0);
      chk("rst_data1", bd1, 0);
      chk("rst_nwe1", nwe1, 1);
      chk("rst_nboot1", nb1, 1);
      chk("rst_cpurst1", cr1, 0);

      // short image, IN_VALID toggling
      rst1 = 1;
      idx = 0;
      for (int c = 0; c < 200 && nb1; c++) begin
         v1 = (c % 2 == 1);
         d1 = pat[idx & 3];
         acc = v1 && rdy1;
         tick();
         if (acc) idx++;
      end
      chk("b_nboot", nb1, 0);
      chk("b_cpurst", cr1, 1);
      chk("b_writes", wr[1], 4);
      chk("b_addr", a1, 3);
      chk("b_qempty", q1.size(), 0);

      // offers after DONE are ignored
      v1 = 1;
      d1 = 8'hFF;
      repeat (20) begin
         tick();
         chk("c_ready", rdy1, 0);
         chk("c_nwe", nwe1, 1);
         chk("c_addr", a1, 3);
      end
      chk("c_writes", wr[1], 4);

      // reset from DONE, then random valid/data reloads
      for (int r = 0; r < 3; r++) begin
         rst1 = 0;
         v1 = 0;
         tick();
         chk("d_rst_nboot", nb1, 1);
         chk("d_rst_cpurst", cr1, 0);
         chk("d_rst_addr", a1, 0);
         rst1 = 1;
         need = 1;
         for (int c = 0; c < 400 && nb1; c++) begin
            v1 = 1'($urandom % 2);
            if (need) d1 = 8'($urandom);
            need = 0;
            acc = v1 && rdy1;
            tick();
            if (acc) need = 1;
         end
         chk("d_nboot", nb1, 0);
         chk("d_writes", wr[1], 4);
      end

      // full 4096-byte image with IN_VALID held high
      rst0 = 1;
      cnt = 0;
      fall = 0;
      for (int k = 1; k <= 20000 && fall == 0; k++) begin
         v0 = 1;
         d0 = cnt[7:0];
         acc = rdy0;
         tick();
         if (acc) cnt++;
         if (!nb0) fall = k;
      end
      chk("e_fall_cycle", fall, 1 + 4 * 4096);
      chk("e_writes", wr[0], 4096);
      chk("e_addr", a0, 4095);
      chk("e_cpurst", cr0, 1);

      // reset asserted during the write strobe at address 7
      rst0 = 0;
      tick();
      rst0 = 1;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         v0 = 1;
         d0 = 8'($urandom);
         tick();
         if (!nwe0 && a0 == 12'd7) found = 1;
      end
      chk("f_reach7", found, 1);
      rst0 = 0;
      #1;
      chk("f_async_nwe", nwe0, 1);
      chk("f_async_addr", a0, 0);
      chk("f_async_cpurst", cr0, 0);
      chk("f_async_nboot", nb0, 1);
      tick();
      tick();
      rst0 = 1;
      v0 = 1;
      d0 = 8'h77;
      for (int c = 0; c < 50 && nwe0; c++) tick();
      chk("f_first_addr", a0, 0);
      chk("f_first_data", bd0, 8'h77);

      // IN_VALID low in WAIT at address 2
      for (int c = 0; c < 50; c++) begin
         if (rdy0 && a0 == 12'd2) break;
         v0 = 1;
         d0 = 8'($urandom);
         tick();
      end
      v0 = 0;
      chk("g_ready", rdy0, 1);
      chk("g_start_addr", a0, 2);
      repeat (1000) begin
         tick();
         chk("g_addr", a0, 2);
         chk("g_nwe", nwe0, 1);
         chk("g_nboot", nb0, 1);
      end
      chk("g_writes", wr[0], 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
